// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with manual select, timed auto-scan
// and freeze; out_ch change is flagged by a one-cycle strobe.
module mux_scan_n #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic                      hold,
  input  logic [SELW-1:0]           select,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]          out_mux,
  output logic [SELW-1:0]           out_ch,
  output logic                      ch_strobe
);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    FROZEN = 2'd2
  } state_e;

  localparam logic [7:0] DLAST = 8'(DWELL - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d, cnt_base;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [WIDTH-1:0] mux_q, mux_d;
  logic             stb_q, stb_d;

  // Entry from MANUAL always starts a fresh dwell; resume keeps the count.
  assign cnt_base = (state_q == MANUAL) ? 8'd0 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    mux_d   = mux_q;
    stb_d   = 1'b0;
    if (hold) begin
      state_d = FROZEN;
    end else begin
      if (!mode) begin
        state_d = MANUAL;
        cnt_d   = 8'd0;
        ch_d    = select;
      end else begin
        state_d = SCAN;
        if (cnt_base == DLAST) begin
          cnt_d = 8'd0;
          ch_d  = ch_q + SELW'(1);
        end else begin
          cnt_d = cnt_base + 8'd1;
          ch_d  = ch_q;
        end
      end
      mux_d = in_bus[int'(ch_d)*WIDTH +: WIDTH];
      stb_d = (ch_d != ch_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MANUAL;
      cnt_q   <= 8'd0;
      ch_q    <= '0;
      mux_q   <= '0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      mux_q   <= mux_d;
      stb_q   <= stb_d;
    end
  end

  assign out_mux   = mux_q;
  assign out_ch    = ch_q;
  assign ch_strobe = stb_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: default instance against a cycle model
// scoreboard, plus a DWELL=1 / 8-channel instance.
module tb_mux_scan_n;

  logic        clk = 1'b0;
  logic        reset, mode, hold;
  logic [1:0]  select;
  logic [15:0] in_bus;
  logic [3:0]  out_mux;
  logic [1:0]  out_ch;
  logic        ch_strobe;

  logic        reset2, mode2, hold2;
  logic [2:0]  select2;
  logic [31:0] in_bus2;
  logic [3:0]  out_mux2;
  logic [2:0]  out_ch2;
  logic        ch_strobe2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] mux;
    logic [1:0] ch;
    logic       stb;
  } exp_t;

  exp_t sb[$];
  int   sb2[$];
  exp_t e;

  int m_cnt, m_ch, m_mux, m_stb;

  always #5 clk = ~clk;

  mux_scan_n #(.WIDTH(4), .CHANNELS(4), .DWELL(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .hold(hold),
    .select(select), .in_bus(in_bus),
    .out_mux(out_mux), .out_ch(out_ch), .ch_strobe(ch_strobe)
  );

  mux_scan_n #(.WIDTH(4), .CHANNELS(8), .DWELL(1)) dut2 (
    .clk(clk), .reset(reset2), .mode(mode2), .hold(hold2),
    .select(select2), .in_bus(in_bus2),
    .out_mux(out_mux2), .out_ch(out_ch2), .ch_strobe(ch_strobe2)
  );

  // Model one edge from the current inputs, push the expectation, clock.
  task automatic cyc();
    int nch;
    logic [15:0] bus;
    bus = in_bus;
    if (reset) begin
      m_cnt = 0; m_ch = 0; m_mux = 0; m_stb = 0;
    end else if (hold) begin
      m_stb = 0;
    end else begin
      if (!mode) begin
        nch = select;
        m_cnt = 0;
      end else if (m_cnt == 3) begin
        m_cnt = 0;
        nch = (m_ch + 1) % 4;
      end else begin
        m_cnt = m_cnt + 1;
        nch = m_ch;
      end
      m_stb = (nch != m_ch) ? 1 : 0;
      m_ch  = nch;
      m_mux = bus[nch*4 +: 4];
    end
    e.mux = 4'(m_mux);
    e.ch  = 2'(m_ch);
    e.stb = 1'(m_stb);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pop(output exp_t x);
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL sb_empty: got nothing queued, required an entry");
      x.mux = 'x; x.ch = 'x; x.stb = 'x;
    end else begin
      x = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    exp_t x;
    reset = 1; hold = 1; mode = 1; select = 1; in_bus = 16'hFFFF;
    cyc();
    pop(x);
    checks++;
    if ({out_mux, out_ch, ch_strobe} !== 7'd0 ||
        {out_mux, out_ch, ch_strobe} !== {x.mux, x.ch, x.stb}) begin
      errors++;
      $display("FAIL reset: mux=%h ch=%0d stb=%b required 0 0 0",
               out_mux, out_ch, ch_strobe);
    end
    reset = 0; hold = 0; mode = 0; select = 0;
  endtask

  task automatic test_manual();
    exp_t x;
    in_bus = 16'hDCBA; select = 2;
    cyc();
    pop(x);
    checks++;
    if (out_mux !== 4'hC || out_ch !== 2'd2 || ch_strobe !== 1'b1 ||
        x.mux !== 4'hC) begin
      errors++;
      $display("FAIL manual_sel: mux=%h ch=%0d stb=%b required C 2 1",
               out_mux, out_ch, ch_strobe);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      pop(x);
      checks++;
      if (out_mux !== x.mux || out_ch !== x.ch || ch_strobe !== 1'b0) begin
        errors++;
        $display("FAIL manual_resel%0d: mux=%h ch=%0d stb=%b required %h %0d 0",
                 i, out_mux, out_ch, ch_strobe, x.mux, x.ch);
      end
    end
  endtask

  task automatic test_live();
    exp_t x;
    logic [3:0] v [3];
    v[0] = 4'h3; v[1] = 4'h5; v[2] = 4'hA;
    select = 0;
    for (int i = 0; i < 3; i++) begin
      in_bus[3:0] = v[i];
      cyc();
      pop(x);
      checks++;
      if (out_mux !== v[i] || out_mux !== x.mux || out_ch !== 2'd0 ||
          ch_strobe !== x.stb || (i > 0 && ch_strobe !== 1'b0)) begin
        errors++;
        $display("FAIL live%0d: mux=%h stb=%b required %h %b",
                 i, out_mux, ch_strobe, v[i], x.stb);
      end
    end
  endtask

  task automatic test_scan_wrap();
    exp_t x;
    int nstb = 0;
    int seq [16] = '{3,3,3,0,0,0,0,1,1,1,1,2,2,2,2,3};
    in_bus = 16'h4321;
    select = 3;
    cyc();
    pop(x);
    mode = 1;
    for (int i = 0; i < 16; i++) begin
      in_bus = 16'(in_bus + 16'h1111);
      cyc();
      pop(x);
      if (ch_strobe === 1'b1) nstb++;
      checks++;
      if (out_ch !== 2'(seq[i]) || out_ch !== x.ch ||
          out_mux !== x.mux || ch_strobe !== x.stb) begin
        errors++;
        $display("FAIL scan%0d: ch=%0d mux=%h stb=%b required %0d %h %b",
                 i, out_ch, out_mux, ch_strobe, seq[i], x.mux, x.stb);
      end
    end
    checks++;
    if (nstb != 4) begin
      errors++;
      $display("FAIL scan_strobes: got %0d required 4", nstb);
    end
  endtask

  task automatic test_freeze();
    exp_t x;
    logic [3:0] m0;
    mode = 0; select = 1;
    cyc(); pop(x);
    mode = 1;
    cyc(); pop(x);
    cyc(); pop(x);
    m0 = out_mux;
    hold = 1;
    for (int i = 0; i < 10; i++) begin
      in_bus = 16'($urandom);
      mode = 1'($urandom);
      select = 2'($urandom);
      cyc();
      pop(x);
      checks++;
      if (out_ch !== 2'd1 || out_mux !== m0 || ch_strobe !== 1'b0 ||
          out_ch !== x.ch || out_mux !== x.mux) begin
        errors++;
        $display("FAIL freeze%0d: ch=%0d mux=%h stb=%b required 1 %h 0",
                 i, out_ch, out_mux, ch_strobe, m0);
      end
    end
    hold = 0; mode = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      pop(x);
      checks++;
      if (out_ch !== 2'(i + 1) || ch_strobe !== 1'(i) ||
          out_mux !== x.mux || out_ch !== x.ch) begin
        errors++;
        $display("FAIL resume%0d: ch=%0d stb=%b required %0d %0d",
                 i, out_ch, ch_strobe, i + 1, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    int seq [6] = '{0,0,0,1,1,1};
    cyc(); pop(x);
    cyc(); pop(x);
    reset = 1; hold = 1;
    cyc();
    pop(x);
    checks++;
    if (out_mux !== 4'h0 || out_ch !== 2'd0 || ch_strobe !== 1'b0 ||
        x.ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: mux=%h ch=%0d stb=%b required 0 0 0",
               out_mux, out_ch, ch_strobe);
    end
    reset = 0; hold = 0; mode = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      pop(x);
      checks++;
      if (out_ch !== 2'(seq[i]) || out_ch !== x.ch ||
          out_mux !== x.mux || ch_strobe !== x.stb) begin
        errors++;
        $display("FAIL restart%0d: ch=%0d stb=%b required %0d %b",
                 i, out_ch, ch_strobe, seq[i], x.stb);
      end
    end
  endtask

  task automatic test_mode_switch();
    exp_t x;
    mode = 0; select = 3;
    cyc();
    pop(x);
    checks++;
    if (out_ch !== 2'd3 || ch_strobe !== 1'b1 || out_mux !== x.mux) begin
      errors++;
      $display("FAIL scan_to_manual: ch=%0d stb=%b required 3 1",
               out_ch, ch_strobe);
    end
  endtask

  task automatic test_dwell1();
    int exp;
    in_bus2 = 32'h76543210; hold2 = 0; select2 = 0; mode2 = 1;
    reset2 = 1;
    @(posedge clk); #1;
    checks++;
    if (out_ch2 !== 3'd0 || ch_strobe2 !== 1'b0 || out_mux2 !== 4'd0) begin
      errors++;
      $display("FAIL d1_reset: ch=%0d stb=%b required 0 0",
               out_ch2, ch_strobe2);
    end
    reset2 = 0;
    for (int i = 1; i <= 9; i++) begin
      sb2.push_back(i % 8);
      @(posedge clk); #1;
      exp = sb2.pop_front();
      checks++;
      if (out_ch2 !== 3'(exp) || ch_strobe2 !== 1'b1 ||
          out_mux2 !== 4'(exp)) begin
        errors++;
        $display("FAIL d1_step%0d: ch=%0d mux=%h stb=%b required %0d %0d 1",
                 i, out_ch2, out_mux2, ch_strobe2, exp, exp);
      end
    end
  endtask

  initial begin
    reset = 1; mode = 0; hold = 0; select = 0; in_bus = 0;
    reset2 = 1; mode2 = 0; hold2 = 0; select2 = 0; in_bus2 = 0;
    m_cnt = 0; m_ch = 0; m_mux = 0; m_stb = 0;
    @(posedge clk); #1;
    test_reset();
    test_manual();
    test_live();
    test_scan_wrap();
    test_freeze();
    test_reset_mid();
    test_mode_switch();
    test_dwell1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
